aes_inv_cipher_iter: RTL and testbench



---
 rtl/aes_inv_cipher_iter.sv | 204 ++++++++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption: key expanded once into an 11-entry store, then one inverse round
// per clock from rk10 down to rk0. Define AES_INV_ZEROIZE_EN to add the zeroize input.
module aes_inv_cipher_iter #(
   parameter int unsigned CLR_OUT_ON_LD = 0
) (
   input  logic         clk,
   input  logic         rst,
`ifdef AES_INV_ZEROIZE_EN
   input  logic         zeroize,
`endif
   input  logic         kld,
   input  logic [127:0] key,
   input  logic         ld,
   input  logic [127:0] text_in,
   output logic         key_rdy,
   output logic         busy,
   output logic         done,
   output logic [127:0] text_out
);

   typedef enum logic [1:0] {StIdle, StKexp, StKrdy, StRun} state_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
      a2   = gmul(a, a);
      a3   = gmul(a2, a);
      a6   = gmul(a3, a3);
      a12  = gmul(a6, a6);
      a15  = gmul(a12, a3);
      a30  = gmul(a15, a15);
      a60  = gmul(a30, a30);
      a120 = gmul(a60, a60);
      a240 = gmul(a120, a120);
      return gmul(gmul(a240, a12), a2);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
      logic [15:0] t;
      t = {a, a} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [127:0] key_step(input logic [127:0] rk, input logic [7:0] rcon);
      logic [31:0] w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = rk;
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Byte 4*col+row sits at [127-8*(4*col+row) -: 8]; row r rotates right by r.
   function automatic logic [127:0] inv_sr_sb(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = s[127-32*c -: 32];
         o[127-32*c -: 32] = {
            gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
      end
      return o;
   endfunction

   state_e       st_q;
   logic [3:0]   kcnt_q, rnd_q;
   logic [7:0]   rcon_q;
   logic [127:0] kw_q, blk_q, text_out_q;
   logic [127:0] rk_q [11];
   logic         key_rdy_q, busy_q, done_q;

   logic         halt, kld_go, kexp_go, kexp_end, ld_go, run_go, fin_go;
   logic [127:0] rk_next, rnd_out, blk_next;

`ifdef AES_INV_ZEROIZE_EN
   assign halt = rst | zeroize;
`else
   assign halt = rst;
`endif
   assign kld_go   = !halt && kld;
   assign kexp_go  = !halt && !kld && (st_q == StKexp) && (kcnt_q <= 4'd10);
   assign kexp_end = !halt && !kld && (st_q == StKexp) && (kcnt_q > 4'd10);
   assign ld_go    = !halt && !kld && (st_q == StKrdy) && ld;
   assign run_go   = !halt && !kld && (st_q == StRun) && (rnd_q != 4'd0);
   assign fin_go   = !halt && !kld && (st_q == StRun) && (rnd_q == 4'd0);

   assign rk_next  = key_step(kw_q, rcon_q);
   // Same expression yields the final-round plaintext when rnd_q reaches 0.
   assign rnd_out  = inv_sr_sb(blk_q) ^ rk_q[rnd_q];
   assign blk_next = inv_mix(rnd_out);

   always_ff @(posedge clk) begin
      if (halt) begin
         st_q      <= StIdle;
         key_rdy_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rnd_q     <= 4'd0;
         kcnt_q    <= 4'd0;
         if (rst) text_out_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (kld_go) begin
            st_q      <= StKexp;
            key_rdy_q <= 1'b0;
            busy_q    <= 1'b0;
            rnd_q     <= 4'd0;
            kcnt_q    <= 4'd1;
         end else if (kexp_go) begin
            kcnt_q <= kcnt_q + 4'd1;
         end else if (kexp_end) begin
            st_q      <= StKrdy;
            key_rdy_q <= 1'b1;
            kcnt_q    <= 4'd0;
         end else if (ld_go) begin
            st_q   <= StRun;
            busy_q <= 1'b1;
            rnd_q  <= 4'd9;
            if (CLR_OUT_ON_LD != 0) text_out_q <= '0;
         end else if (run_go) begin
            rnd_q <= rnd_q - 4'd1;
         end else if (fin_go) begin
            st_q       <= StKrdy;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            text_out_q <= rnd_out;
         end
      end
   end

   // Key material is deliberately not reset; only zeroize scrubs it.
   always_ff @(posedge clk) begin
`ifdef AES_INV_ZEROIZE_EN
      if (zeroize) begin
         for (int i = 0; i < 11; i++) rk_q[i] <= '0;
         kw_q   <= '0;
         blk_q  <= '0;
         rcon_q <= 8'h00;
      end else begin
`else
      begin
`endif
         if (kld_go) begin
            rk_q[0] <= key;
            kw_q    <= key;
            rcon_q  <= 8'h01;
         end else if (kexp_go) begin
            rk_q[kcnt_q] <= rk_next;
            kw_q         <= rk_next;
            rcon_q       <= xtime(rcon_q);
         end
         if (ld_go) blk_q <= text_in ^ rk_q[10];
         else if (run_go) blk_q <= blk_next;
      end
   end

   assign key_rdy  = key_rdy_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign text_out = text_out_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS vectors and random blocks against a table-driven model,
// with a done-driven scoreboard checking both plaintext and completion cycle.
module tb_aes_inv_cipher_iter;

   localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] BKey  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] BRk10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] BCt   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] BPt   = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk = 1'b0;
   logic         rst, kld, ld;
   logic [127:0] key, text_in, text_out;
   logic         key_rdy, busy, done;
`ifdef AES_INV_ZEROIZE_EN
   logic         zeroize;
`endif

   int           checks = 0;
   int           failures = 0;
   int unsigned  cyc = 0;

   typedef struct {
      logic [127:0] pt;
      int unsigned  due;
   } exp_t;
   exp_t         sb_q[$];

   logic [7:0]   sb[256];
   logic [7:0]   isb[256];
   logic [31:0]  w[44];

   aes_inv_cipher_iter #(.CLR_OUT_ON_LD(0)) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef AES_INV_ZEROIZE_EN
      .zeroize  (zeroize),
`endif
      .kld      (kld),
      .key      (key),
      .ld       (ld),
      .text_in  (text_in),
      .key_rdy  (key_rdy),
      .busy     (busy),
      .done     (done),
      .text_out (text_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      int unsigned p, x, y;
      p = 0;
      x = a;
      y = b;
      while (y != 0) begin
         if (y[0]) p ^= x;
         x = x << 1;
         if (x[8]) x ^= 32'h11b;
         y = y >> 1;
      end
      return p[7:0];
   endfunction

   // S-box by brute-force inverse search followed by the bitwise affine map.
   task automatic build_tables();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] b, o, c;
         b = 8'h00;
         c = 8'h63;
         for (int y = 1; y < 256; y++)
            if (gm(x[7:0], y[7:0]) == 8'h01) b = y[7:0];
         for (int i = 0; i < 8; i++)
            o[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
         sb[x]  = o;
         isb[o] = x[7:0];
      end
   endtask

   function automatic void expand(input logic [127:0] k);
      logic [7:0]  rc;
      logic [31:0] t;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
            rc = gm(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
   endfunction

   function automatic logic [127:0] model_dec(input logic [127:0] ct);
      logic [7:0]   s[4][4];
      logic [7:0]   t[4][4];
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = ct[127-8*(4*c+r) -: 8] ^ w[40+c][31-8*r -: 8];
      for (int rnd = 9; rnd >= 0; rnd--) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = isb[s[r][(c-r+4)%4]] ^ w[4*rnd+c][31-8*r -: 8];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[r][c] = (rnd == 0) ? t[r][c] :
                  gm(t[r][c], 8'h0e) ^ gm(t[(r+1)%4][c], 8'h0b) ^
                  gm(t[(r+2)%4][c], 8'h0d) ^ gm(t[(r+3)%4][c], 8'h09);
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[r][c];
      return o;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Loads a key, checks key_rdy stays low for 11 cycles then rises; optionally pokes ld mid-expansion.
   task automatic do_kld(input logic [127:0] k, input bit poke_ld);
      kld = 1'b1;
      key = k;
      step(1);
      kld = 1'b0;
      expand(k);
      for (int j = 0; j <= 10; j++) begin
         chk("key_rdy_low", key_rdy, 1'b0);
         if (poke_ld && j == 5) begin
            ld = 1'b1;
            text_in = rnd128();
         end else begin
            ld = 1'b0;
         end
         step(1);
      end
      ld = 1'b0;
      chk("key_rdy_rise", key_rdy, 1'b1);
   endtask

   task automatic do_ld(input logic [127:0] ct, input bit acc, input logic [127:0] pt);
      int unsigned e;
      e = cyc + 1;
      ld = 1'b1;
      text_in = ct;
      step(1);
      ld = 1'b0;
      if (acc) sb_q.push_back('{pt: pt, due: e + 10});
   endtask

   // Scoreboard monitor.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("done_cycle", cyc, e.due);
               chk("text_out", text_out, e.pt);
            end
         end else if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_done: got no done expected done at cycle %0d", e.due);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [127:0] ct;
      rst = 1'b1;
      kld = 1'b0;
      ld = 1'b0;
      key = '0;
      text_in = '0;
`ifdef AES_INV_ZEROIZE_EN
      zeroize = 1'b0;
`endif
      build_tables();
      step(3);
      rst = 1'b0;
      chk("rst_key_rdy", key_rdy, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_text_out", text_out, '0);
      do_ld(rnd128(), 1'b0, '0);
      step(12);
      chk("idle_ld_busy", busy, 1'b0);

      do_kld(C1Key, 1'b0);
      do_ld(C1Ct, 1'b1, C1Pt);
      chk("busy_after_ld", busy, 1'b1);
      step(10);
      do_ld(C1Ct, 1'b1, C1Pt);
      step(3);
      do_ld(rnd128(), 1'b0, '0);
      chk("text_out_hold", text_out, C1Pt);
      step(8);
      chk("busy_after_done", busy, 1'b0);

      do_kld(BKey, 1'b0);
      chk("rk10_appB", dut.rk_q[10], BRk10);
      do_ld(BCt, 1'b1, BPt);
      step(11);

      do_ld(rnd128(), 1'b0, '0);
      step(4);
      do_kld(rnd128(), 1'b1);
      ct = rnd128();
      do_ld(ct, 1'b1, model_dec(ct));
      step(11);

      do_ld(rnd128(), 1'b0, '0);
      step(4);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("rst_mid_done", done, 1'b0);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_key_rdy", key_rdy, 1'b0);
      chk("rst_mid_text_out", text_out, '0);
      do_ld(rnd128(), 1'b0, '0);
      step(12);
      chk("rst_ld_ignored", busy, 1'b0);

      for (int k = 0; k < 4; k++) begin
         do_kld(rnd128(), 1'b0);
         for (int b = 0; b < 3; b++) begin
            ct = rnd128();
            do_ld(ct, 1'b1, model_dec(ct));
            if ($urandom_range(0, 1) == 1) begin
               step(2);
               do_ld(rnd128(), 1'b0, '0);
               step(7);
            end else begin
               step(10 + $urandom_range(0, 3));
            end
         end
         step(2);
      end

      step(1000);
      ct = rnd128();
      do_ld(ct, 1'b1, model_dec(ct));
      step(11);

`ifdef AES_INV_ZEROIZE_EN
      do_ld(rnd128(), 1'b0, '0);
      step(3);
      zeroize = 1'b1;
      step(1);
      zeroize = 1'b0;
      chk("zeroize_key_rdy", key_rdy, 1'b0);
      chk("zeroize_busy", busy, 1'b0);
      do_ld(rnd128(), 1'b0, '0);
      step(12);
      chk("zeroize_ld_ignored", busy, 1'b0);
`endif

      step(2);
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
